// File: rtl/operand_issue_pkg.sv
// Shared field widths and helpers for the operand_issue slice.
package operand_issue_pkg;

  localparam int OP_W   = 3;
  localparam int FORM_W = 1;
  localparam int VEC_W  = 2;
  localparam int HDR_W  = OP_W + FORM_W + VEC_W;

  typedef logic [1:0] fifo_cnt_t;
  localparam fifo_cnt_t FIFO_DEPTH = 2'd2;

  // Packed instruction: op | form | vec | ra | rb | rc | rd (MSB to LSB).
  function automatic int instr_width(input int rw);
    return HDR_W + 4 * rw;
  endfunction

endpackage

// File: rtl/operand_issue_if.sv
// Instruction intake, writeback port and datapath presentation bundle.
interface operand_issue_if
  import operand_issue_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
);
  localparam int RW = $clog2(NREGS);
  localparam int IW = instr_width(RW);

  logic             in_valid;
  logic             in_ready;
  logic [IW-1:0]    in_instr;
  logic             wb_en;
  logic [RW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [OP_W-1:0]  op;
  logic             form;
  logic [VEC_W-1:0] vec;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;

  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, op, form, vec, a, b, c, d
  );

  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, op, form, vec, a, b, c, d
  );

endinterface

// File: rtl/operand_issue_fifo.sv
// Two-entry instruction FIFO with synchronous reset; head is always visible.
module issue_fifo
  import operand_issue_pkg::*;
#(
  parameter int IW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [IW-1:0] i_data,
  output fifo_cnt_t     o_count,
  output logic [IW-1:0] o_head
);

  logic [IW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  fifo_cnt_t     r_count;

  // NOTE: storage is left unreset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/operand_issue.sv
// Instruction issue stage: FIFO, 4-read register file, registered datapath
// outputs. Define RAPIDS_WB_BYPASS_EN to forward same-edge writebacks.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  operand_issue_if.slave   bus
);

  localparam int RW       = $clog2(NREGS);
  localparam int IW       = instr_width(RW);
  localparam int VEC_LSB  = 4 * RW;
  localparam int FORM_LSB = VEC_LSB + VEC_W;
  localparam int OP_LSB   = FORM_LSB + FORM_W;

  fifo_cnt_t        w_count;
  logic [IW-1:0]    w_head;
  logic             w_in_ready;
  logic             w_push;
  logic             w_load;
  logic [RW-1:0]    w_idx  [4];
  logic [WIDTH-1:0] w_opnd [4];

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_out_valid;
  logic [OP_W-1:0]  r_op;
  logic             r_form;
  logic [VEC_W-1:0] r_vec;
  logic [WIDTH-1:0] r_opnd [4];

  assign w_in_ready = (w_count < FIFO_DEPTH);
  assign w_push     = bus.in_valid && w_in_ready;
  // No bypass around the FIFO: only entries already buffered can load.
  assign w_load     = (w_count != '0) && (!r_out_valid || bus.out_ready);

  issue_fifo #(.IW(IW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_load),
    .i_data  (bus.in_instr),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_idx[i]  = w_head[(3 - i) * RW +: RW];
      w_opnd[i] = r_regs[w_idx[i]];
`ifdef RAPIDS_WB_BYPASS_EN
      if (bus.wb_en && (bus.wb_addr == w_idx[i])) w_opnd[i] = bus.wb_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (bus.wb_en) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Fields only change on a load, so a stalled presentation stays frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_op        <= '0;
      r_form      <= 1'b0;
      r_vec       <= '0;
      for (int i = 0; i < 4; i++) r_opnd[i] <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_op        <= w_head[OP_LSB +: OP_W];
      r_form      <= w_head[FORM_LSB];
      r_vec       <= w_head[VEC_LSB +: VEC_W];
      for (int i = 0; i < 4; i++) r_opnd[i] <= w_opnd[i];
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.op        = r_op;
  assign bus.form      = r_form;
  assign bus.vec       = r_vec;
  assign bus.a         = r_opnd[0];
  assign bus.b         = r_opnd[1];
  assign bus.c         = r_opnd[2];
  assign bus.d         = r_opnd[3];

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: scoreboard of expected presentations,
// checked by a monitor whenever the datapath consumes an instruction.
module tb_operand_issue;
  import operand_issue_pkg::*;

  localparam int WIDTH = 4;
  localparam int NREGS = 4;
  localparam int RW    = 2;
  localparam int IW    = 14;

  typedef struct packed {
    logic [2:0]       op;
    logic             form;
    logic [1:0]       vec;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_issue_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

  operand_issue #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t             sb [$];
  logic [WIDTH-1:0] model [NREGS];
  int               checks   = 0;
  int               failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic form,
                                       input logic [1:0] vec, input logic [1:0] ra,
                                       input logic [1:0] rb, input logic [1:0] rc,
                                       input logic [1:0] rd);
    return {op, form, vec, ra, rb, rc, rd};
  endfunction

  function automatic exp_t predict(input logic [IW-1:0] ins);
    exp_t e;
    e.op   = ins[13:11];
    e.form = ins[10];
    e.vec  = ins[9:8];
    e.a    = model[ins[7:6]];
    e.b    = model[ins[5:4]];
    e.c    = model[ins[3:2]];
    e.d    = model[ins[1:0]];
    return e;
  endfunction

  function automatic logic [31:0] observed();
    exp_t o;
    o = {bus.op, bus.form, bus.vec, bus.a, bus.b, bus.c, bus.d};
    return 32'(o);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the instruction on the input until a handshake occurs (bounded).
  task automatic offer(input logic [IW-1:0] ins);
    logic accepted;
    logic rdy;
    accepted     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    for (int n = 0; n < 20 && !accepted; n++) begin
      rdy = bus.in_ready;
      step();
      if (rdy) accepted = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("offer_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic send(input logic [IW-1:0] ins);
    sb.push_back(predict(ins));
    offer(ins);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) step();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic wb_write(input logic [1:0] addr, input logic [WIDTH-1:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    step();
    bus.wb_en   = 1'b0;
    model[addr] = data;
  endtask

  // Inputs change just after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        check("out_fields", observed(), 32'(sb[0]));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IW-1:0] ins;
    exp_t          e;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_fields", observed(), 32'd0);

    // Basic load: fields and operands from the register file, one-edge latency.
    for (int i = 0; i < 4; i++) wb_write(2'(i), 4'(i + 1));
    bus.out_ready = 1'b1;
    send(mk(3'd5, 1'b1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0));
    check("lat_not_yet", 32'(bus.out_valid), 32'd0);
    step();
    check("lat_presented", 32'(bus.out_valid), 32'd1);
    check("basic_fields", observed(), 32'({3'd5, 1'b1, 2'd2, 4'd4, 4'd3, 4'd2, 4'd1}));
    drain();
    step();
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: fill output register and FIFO, then drain in order.
    bus.out_ready = 1'b0;
    send(mk(3'd1, 1'b0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3));
    send(mk(3'd2, 1'b1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0));
    send(mk(3'd3, 1'b0, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0));
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    ins = mk(3'd7, 1'b1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    step();
    step();
    step();
    check("held_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_head_op", 32'(bus.op), 32'd1);
    check("stall_head_a", 32'(bus.a), 32'd1);
    bus.out_ready = 1'b1;
    send(ins);
    drain();
    step();
    check("drained_in_ready", 32'(bus.in_ready), 32'd1);

    // Writeback to a presented source during a stall must not disturb it.
    bus.out_ready = 1'b0;
    send(mk(3'd6, 1'b1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd3));
    step();
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    wb_write(2'd1, 4'd9);
    step();
    step();
    check("stall_a_frozen", 32'(bus.a), 32'd2);
    check("stall_b_frozen", 32'(bus.b), 32'd2);
    send(mk(3'd2, 1'b0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1));
    check("stall_a_still", 32'(bus.a), 32'd2);
    bus.out_ready = 1'b1;
    drain();

    // Writeback on the load edge of a reader: bypassed or old value.
    ins = mk(3'd1, 1'b0, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3);
    e = predict(ins);
`ifdef RAPIDS_WB_BYPASS_EN
    e.a = 4'd7;
`endif
    sb.push_back(e);
    offer(ins);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 2'd2;
    bus.wb_data = 4'd7;
    step();
    bus.wb_en = 1'b0;
    model[2]  = 4'd7;
    check("load_edge_wb_a", 32'(bus.a), 32'(e.a));
    send(mk(3'd4, 1'b1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0));
    drain();

    // Reset while FIFO is full and an instruction is presented.
    bus.out_ready = 1'b0;
    offer(mk(3'd3, 1'b1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3));
    offer(mk(3'd5, 1'b0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1));
    offer(mk(3'd6, 1'b1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2));
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_fields", observed(), 32'd0);
    bus.out_ready = 1'b1;
    send(mk(3'd5, 1'b1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3));
    drain();
    step();
    check("final_out_valid", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
